// File: rtl/led_pwm.sv
// Memory-mapped multi-channel LED PWM driver with shared prescaler, per-channel
// shadowed duty (frame-aligned updates) and optional blink gating.
module led_pwm #(
   parameter int unsigned NUM_CHANNELS = 8,
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned PRESC_BITS   = 16,
   parameter int unsigned BLINK_BITS   = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [31:0]             address_in,
   input  logic                    sel_in,
   input  logic                    read_in,
   output logic [31:0]             read_value_out,
   input  logic [3:0]              write_mask_in,
   input  logic [31:0]             write_value_in,
   output logic                    ready_out,
   output logic [NUM_CHANNELS-1:0] pwm_out
);

   logic [3:0]              idx;
   logic                    wr_en;
   logic                    wr_presc;
   logic                    wr_blink;
   logic [31:0]             cur_word;
   logic [31:0]             wr_word;
   logic                    tick;
   logic                    wrap;

   logic                    enable_q, enable_d;
   logic                    blink_en_q, blink_en_d;
   logic [PRESC_BITS-1:0]   presc_q, presc_d;
   logic [PRESC_BITS-1:0]   pcnt_q, pcnt_d;
   logic [BLINK_BITS-1:0]   blink_q, blink_d;
   logic [BLINK_BITS-1:0]   bcnt_q, bcnt_d;
   logic                    phase_q, phase_d;
   logic [NUM_CHANNELS-1:0] bmask_q, bmask_d;
   logic [PWM_BITS-1:0]     fcnt_q, fcnt_d;
   logic [PWM_BITS-1:0]     duty_q   [NUM_CHANNELS];
   logic [PWM_BITS-1:0]     duty_d   [NUM_CHANNELS];
   logic [PWM_BITS-1:0]     shadow_q [NUM_CHANNELS];
   logic [PWM_BITS-1:0]     shadow_d [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] pwm_q, pwm_d;

   logic                    unused_bus;

   assign idx      = address_in[5:2];
   assign wr_en    = sel_in & (|write_mask_in);
   assign wr_presc = wr_en && (idx == 4'd1);
   assign wr_blink = wr_en && (idx == 4'd2);

   assign unused_bus = ^{address_in[31:6], address_in[1:0], read_in, wr_word};

   // Register view of the addressed word, shared by the read path and the byte-lane merge.
   always_comb begin
      cur_word = '0;
      case (idx)
         4'd0: cur_word[1:0] = {blink_en_q, enable_q};
         4'd1: cur_word[PRESC_BITS-1:0] = presc_q;
         4'd2: cur_word[BLINK_BITS-1:0] = blink_q;
         4'd3: cur_word[NUM_CHANNELS-1:0] = bmask_q;
         default: begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
               if (32'(idx) == i + 32'd4) cur_word[PWM_BITS-1:0] = duty_q[i];
            end
         end
      endcase
   end

   always_comb begin
      wr_word = cur_word;
      for (int unsigned b = 0; b < 4; b++) begin
         if (write_mask_in[b]) wr_word[8*b +: 8] = write_value_in[8*b +: 8];
      end
   end

   assign read_value_out = sel_in ? cur_word : '0;
   assign ready_out      = sel_in;

   always_comb begin
      enable_d   = enable_q;
      blink_en_d = blink_en_q;
      presc_d    = presc_q;
      blink_d    = blink_q;
      bmask_d    = bmask_q;
      duty_d     = duty_q;

      if (wr_en) begin
         case (idx)
            4'd0: begin
               enable_d   = wr_word[0];
               blink_en_d = wr_word[1];
            end
            4'd1: presc_d = wr_word[PRESC_BITS-1:0];
            4'd2: blink_d = wr_word[BLINK_BITS-1:0];
            4'd3: bmask_d = wr_word[NUM_CHANNELS-1:0];
            default: begin
               for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                  if (32'(idx) == i + 32'd4) duty_d[i] = wr_word[PWM_BITS-1:0];
               end
            end
         endcase
      end
   end

   assign tick = (pcnt_q == presc_q);
   assign wrap = tick && (fcnt_q == '1);

   always_comb begin
      pcnt_d   = pcnt_q;
      fcnt_d   = fcnt_q;
      bcnt_d   = bcnt_q;
      phase_d  = phase_q;
      shadow_d = shadow_q;

      if (!enable_q) begin
         pcnt_d   = '0;
         fcnt_d   = '0;
         bcnt_d   = '0;
         phase_d  = 1'b0;
         shadow_d = duty_q;
      end else begin
         pcnt_d = tick ? '0 : pcnt_q + PRESC_BITS'(1);
         if (wr_presc) pcnt_d = '0;
         if (tick) fcnt_d = fcnt_q + PWM_BITS'(1);
         // Shadow samples the pre-write duty, so a write on the wrap cycle waits one more frame.
         if (wrap) begin
            shadow_d = duty_q;
            if (bcnt_q == blink_q - BLINK_BITS'(1)) begin
               bcnt_d  = '0;
               phase_d = ~phase_q;
            end else begin
               bcnt_d = bcnt_q + BLINK_BITS'(1);
            end
         end
         if (blink_q == '0) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
         end
         if (wr_blink) bcnt_d = '0;
      end
   end

   always_comb begin
      pwm_d = '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         pwm_d[i] = enable_q
                  & ((shadow_q[i] == '1) | (fcnt_q < shadow_q[i]))
                  & ~(blink_en_q & phase_q & bmask_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         enable_q   <= 1'b0;
         blink_en_q <= 1'b0;
         presc_q    <= '0;
         pcnt_q     <= '0;
         blink_q    <= '0;
         bcnt_q     <= '0;
         phase_q    <= 1'b0;
         bmask_q    <= '0;
         fcnt_q     <= '0;
         pwm_q      <= '0;
         for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            duty_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         enable_q   <= enable_d;
         blink_en_q <= blink_en_d;
         presc_q    <= presc_d;
         pcnt_q     <= pcnt_d;
         blink_q    <= blink_d;
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
         bmask_q    <= bmask_d;
         fcnt_q     <= fcnt_d;
         pwm_q      <= pwm_d;
         for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            duty_q[i]   <= duty_d[i];
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign pwm_out = pwm_q;

endmodule
